pixel_mem_responder: RTL and testbench

//  Memory-side responder for the single-outstanding pixel read/write request interface.

---
 rtl/pixel_mem_responder.sv | 110 +++++++++++
 tb/tb_pixel_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_mem_responder.sv
// rtl/pixel_mem_responder.sv - single-outstanding pixel read/write responder with backdoor preload
module pixel_mem_responder #(
  parameter int          DEPTH         = 784,
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          READ_LATENCY  = 1,
  parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read_req,
  input  logic                     write_req,
  input  logic [31:0]              addr,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     read_valid,
  output logic                     write_ready,
  output logic                     err,
  output logic                     busy,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count
);

  localparam int AW = $clog2(DEPTH);
  // Initial countdown so that the response lands READ_LATENCY cycles after the request.
  localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 2);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_ACK} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        err_q;
  logic [31:0] rd_data_q;

  logic [31:0] mem [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] widx;
  logic          addr_ok;
  logic [31:0]   rd_value;
  logic          wr_accept;
  logic          ld_ok;

  // Address below BASE_ADDR wraps to a huge offset and fails the range test.
  assign off       = addr - BASE_ADDR;
  assign widx      = off[AW+1:2];
  assign addr_ok   = (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < 32'(DEPTH));
  assign rd_value  = addr_ok ? mem[widx] : DEFAULT_RDATA;
  assign wr_accept = (state == IDLE) && write_req && !read_req;
  assign ld_ok     = ld_en && (32'(ld_addr) < 32'(DEPTH));

  assign read_valid  = (state == RD_RESP);
  assign write_ready = (state == WR_ACK);
  assign busy        = (state != IDLE);
  assign err         = err_q && ((state == RD_RESP) || (state == WR_ACK));

  // Request FSM: accepts in IDLE only, read has priority, counters saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      err_q     <= 1'b0;
      rd_data_q <= 32'd0;
      read_data <= 32'd0;
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (read_req) begin
            err_q     <= !addr_ok;
            rd_data_q <= rd_value;
            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (READ_LATENCY == 1) begin
              state     <= RD_RESP;
              read_data <= rd_value;
            end else begin
              state <= RD_WAIT;
              cnt   <= WAIT_INIT;
            end
          end else if (write_req) begin
            err_q <= !addr_ok;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            state <= WR_ACK;
          end
        end
        RD_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RD_RESP;
            read_data <= rd_data_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_RESP: state <= IDLE;
        WR_ACK:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Image buffer: backdoor and bus writes; the bus write is issued last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_addr] <= ld_data;
    if (wr_accept && addr_ok) mem[widx] <= write_data;
  end

endmodule

// File: tb/tb_pixel_mem_responder.sv
// tb/tb_pixel_mem_responder.sv - randomized and directed checks of pixel_mem_responder against a reference model
module tb_pixel_mem_responder;

  localparam int          DEPTH = 784;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] DEFD  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s      [3];
  logic        rd_req_s   [3];
  logic        wr_req_s   [3];
  logic [31:0] addr_s     [3];
  logic [31:0] wdata_s    [3];
  logic [31:0] rdata_s    [3];
  logic        rvalid_s   [3];
  logic        wready_s   [3];
  logic        err_s      [3];
  logic        busy_s     [3];
  logic        ld_en_s    [3];
  logic [9:0]  ld_addr_s  [3];
  logic [31:0] ld_data_s  [3];
  logic [15:0] rdc_s      [3];
  logic [15:0] wrc_s      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pixel_mem_responder #(
      .DEPTH(DEPTH), .BASE_ADDR(BASE),
      .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 8)),
      .DEFAULT_RDATA(DEFD)
    ) dut (
      .clk(clk), .rst(rst_s[g]),
      .read_req(rd_req_s[g]), .write_req(wr_req_s[g]),
      .addr(addr_s[g]), .write_data(wdata_s[g]),
      .read_data(rdata_s[g]), .read_valid(rvalid_s[g]),
      .write_ready(wready_s[g]), .err(err_s[g]), .busy(busy_s[g]),
      .ld_en(ld_en_s[g]), .ld_addr(ld_addr_s[g]), .ld_data(ld_data_s[g]),
      .rd_count(rdc_s[g]), .wr_count(wrc_s[g])
    );
  end

  logic [31:0] mdl_mem [3][DEPTH];
  int          mdl_rd  [3];
  int          mdl_wr  [3];
  int checks = 0;
  int errors = 0;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
  endfunction

  function automatic logic [15:0] sat(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic bit decode(input logic [31:0] a, output int idx);
    logic [31:0] o;
    o   = a - BASE;
    idx = int'(o / 4);
    return (o % 4 == 0) && (o / 4 < DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(15);
    if (r == 0) return BASE - 32'(4 * $urandom_range(1, 8));
    if (r == 1) return BASE + 32'(4 * $urandom_range(799) + $urandom_range(1, 3));
    return BASE + 32'(4 * $urandom_range(820));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_ld(input int k, input logic [9:0] la, input logic [31:0] d);
    if (int'(la) < DEPTH) mdl_mem[k][int'(la)] = d;
  endtask

  task automatic ld_one(input int k, input logic [9:0] la, input logic [31:0] d);
    ld_en_s[k] = 1'b1; ld_addr_s[k] = la; ld_data_s[k] = d;
    model_ld(k, la, d);
    @(negedge clk);
    ld_en_s[k] = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [31:0] a, input bit ld,
                         input logic [9:0] la, input logic [31:0] ldd);
    int idx, n;
    bit ok;
    logic [31:0] expd;
    ok   = decode(a, idx);
    expd = DEFD;
    if (ok) expd = mdl_mem[k][idx];
    if (ld) model_ld(k, la, ldd);
    mdl_rd[k]++;
    rd_req_s[k] = 1'b1; addr_s[k] = a;
    ld_en_s[k] = ld; ld_addr_s[k] = la; ld_data_s[k] = ldd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rd_req_s[k] = 1'b0; ld_en_s[k] = 1'b0;
    end while (!rvalid_s[k] && n < 40);
    check("rd_latency", 32'(n), 32'(lat(k)));
    check("rd_data", rdata_s[k], expd);
    check("rd_err", 32'(err_s[k]), 32'(!ok));
    check("rd_no_wready", 32'(wready_s[k]), 32'd0);
    check("rd_count", 32'(rdc_s[k]), 32'(sat(mdl_rd[k])));
    @(negedge clk);
    check("rd_idle", {30'd0, busy_s[k], rvalid_s[k]}, 32'd0);
    check("rd_hold", rdata_s[k], expd);
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d, input bit ld,
                          input logic [9:0] la, input logic [31:0] ldd);
    int idx;
    bit ok;
    ok = decode(a, idx);
    if (ld) model_ld(k, la, ldd);
    if (ok) mdl_mem[k][idx] = d;
    mdl_wr[k]++;
    wr_req_s[k] = 1'b1; addr_s[k] = a; wdata_s[k] = d;
    ld_en_s[k] = ld; ld_addr_s[k] = la; ld_data_s[k] = ldd;
    @(negedge clk);
    wr_req_s[k] = 1'b0; ld_en_s[k] = 1'b0;
    check("wr_ready", 32'(wready_s[k]), 32'd1);
    check("wr_err", 32'(err_s[k]), 32'(!ok));
    check("wr_no_rvalid", 32'(rvalid_s[k]), 32'd0);
    check("wr_count", 32'(wrc_s[k]), 32'(sat(mdl_wr[k])));
    @(negedge clk);
    check("wr_idle", {30'd0, busy_s[k], wready_s[k]}, 32'd0);
  endtask

  initial begin
    int idx, cnt;
    logic [31:0] a, expd;
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; rd_req_s[k] = 1'b0; wr_req_s[k] = 1'b0;
      addr_s[k] = '0; wdata_s[k] = '0; ld_en_s[k] = 1'b0;
      ld_addr_s[k] = '0; ld_data_s[k] = '0; mdl_rd[k] = 0; mdl_wr[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_outs", {27'd0, rvalid_s[k], wready_s[k], err_s[k], busy_s[k], 1'b0}, 32'd0);
      check("rst_rdata", rdata_s[k], 32'd0);
      check("rst_counts", {rdc_s[k], wrc_s[k]}, 32'd0);
      rst_s[k] = 1'b0;
    end
    // Preload every word of every instance through the backdoor.
    for (int w = 0; w < DEPTH; w++) begin
      for (int k = 0; k < 3; k++) begin
        ld_en_s[k] = 1'b1; ld_addr_s[k] = 10'(w); ld_data_s[k] = $urandom;
        model_ld(k, 10'(w), ld_data_s[k]);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) ld_en_s[k] = 1'b0;

    // Backdoor load then single-cycle read
    ld_one(0, 10'd29, 32'h0000_007F);
    do_read(0, 32'h1000_0074, 1'b0, '0, '0);
    check("t1_rdata", rdata_s[0], 32'h0000_007F);

    // Bus write then read back
    do_write(0, 32'h1000_0000, 32'h0000_1234, 1'b0, '0, '0);
    do_read(0, 32'h1000_0000, 1'b0, '0, '0);
    check("t3_rdata", rdata_s[0], 32'h0000_1234);

    // Erroneous requests
    do_read(0, 32'h1000_0C40, 1'b0, '0, '0);
    check("t4_default", rdata_s[0], DEFD);
    do_write(0, 32'h1000_0002, 32'hBAD0_BAD0, 1'b0, '0, '0);
    do_read(0, 32'h1000_0000, 1'b0, '0, '0);
    check("t4_unchanged", rdata_s[0], 32'h0000_1234);
    do_read(0, 32'h0FFF_FFFC, 1'b0, '0, '0);
    do_read(0, 32'h1000_0C3C, 1'b0, '0, '0);

    // Same-edge backdoor collisions
    do_read(0, BASE + 32'd20, 1'b1, 10'd5, 32'hCAFE_0005);
    do_read(0, BASE + 32'd20, 1'b0, '0, '0);
    check("ld_after_read", rdata_s[0], 32'hCAFE_0005);
    do_write(0, BASE + 32'd24, 32'h6666_6666, 1'b1, 10'd6, 32'h7777_7777);
    do_read(0, BASE + 32'd24, 1'b0, '0, '0);
    check("bus_beats_ld", rdata_s[0], 32'h6666_6666);

    // Read and write together: read served first, write 2 cycles after read_valid
    void'(decode(BASE + 32'd40, idx));
    expd = mdl_mem[0][idx];
    rd_req_s[0] = 1'b1; wr_req_s[0] = 1'b1; addr_s[0] = BASE + 32'd40; wdata_s[0] = 32'h5555_AAAA;
    @(negedge clk);
    rd_req_s[0] = 1'b0;
    check("t5_rvalid", {30'd0, rvalid_s[0], wready_s[0]}, 32'd2);
    check("t5_rdata", rdata_s[0], expd);
    @(negedge clk);
    check("t5_gap", {30'd0, rvalid_s[0], wready_s[0]}, 32'd0);
    @(negedge clk);
    wr_req_s[0] = 1'b0;
    check("t5_wready", {30'd0, rvalid_s[0], wready_s[0]}, 32'd1);
    mdl_rd[0]++; mdl_wr[0]++; mdl_mem[0][idx] = 32'h5555_AAAA;
    check("t5_counts", {rdc_s[0], wrc_s[0]}, {sat(mdl_rd[0]), sat(mdl_wr[0])});
    @(negedge clk);
    do_read(0, BASE + 32'd40, 1'b0, '0, '0);

    // L=4: busy through the wait, extra read pulses ignored
    void'(decode(BASE + 32'd400, idx));
    expd = mdl_mem[1][idx];
    rd_req_s[1] = 1'b1; addr_s[1] = BASE + 32'd400;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check("t2_busy", 32'(busy_s[1]), 32'd1);
      check("t2_rvalid", 32'(rvalid_s[1]), 32'(n == 4));
      rd_req_s[1] = (n < 4);
    end
    check("t2_rdata", rdata_s[1], expd);
    mdl_rd[1]++;
    @(negedge clk);
    check("t2_after", {30'd0, busy_s[1], rvalid_s[1]}, 32'd0);
    check("t2_count", 32'(rdc_s[1]), 32'(mdl_rd[1]));

    // L=8: reset in RD_WAIT aborts with no response, memory preserved
    do_write(2, BASE + 32'd80, 32'hABCD_0123, 1'b0, '0, '0);
    rd_req_s[2] = 1'b1; addr_s[2] = BASE + 32'd80;
    @(negedge clk);
    rd_req_s[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_busy_pre", 32'(busy_s[2]), 32'd1);
    rst_s[2] = 1'b1;
    #1;
    check("t6_outs", {28'd0, rvalid_s[2], wready_s[2], err_s[2], busy_s[2]}, 32'd0);
    check("t6_counts", {rdc_s[2], wrc_s[2]}, 32'd0);
    check("t6_rdata", rdata_s[2], 32'd0);
    mdl_rd[2] = 0; mdl_wr[2] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_s[2] = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (rvalid_s[2]) cnt++;
    end
    check("t6_no_resp", 32'(cnt), 32'd0);
    do_read(2, BASE + 32'd80, 1'b0, '0, '0);
    check("t6_preserved", rdata_s[2], 32'hABCD_0123);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      int k, op;
      bit ld;
      logic [9:0] la;
      k  = $urandom_range(2);
      op = $urandom_range(2);
      ld = ($urandom_range(3) == 0);
      la = 10'($urandom_range(1023));
      a  = rand_addr();
      if (op == 0)      do_read(k, a, ld, la, $urandom);
      else if (op == 1) do_write(k, a, $urandom, ld, la, $urandom);
      else              ld_one(k, la, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
